// File: rtl/gate_tester_pkg.sv
// rtl/gate_tester_pkg.sv - shared types and constants for the gate tester
// Purpose: FSM state encoding and vector count used by gate_tester.
// Ports: none (package).
package gate_tester_pkg;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_tester_settle_timer.sv
// rtl/gate_tester_settle_timer.sv - loadable settle countdown with zero flag
// Purpose: holds the per-vector settle count for gate_tester.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one; holds at zero
//   o_zero      : count is zero
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_tester.sv
// rtl/gate_tester.sv - exhaustive tester for a 2-input combinational gate
// Purpose: applies vectors 00,01,10,11 to the gate, samples Y after SETTLE+1
//   cycles per vector, and reports pass/fail per run.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : run request, honoured in IDLE only
//   loop        : restart immediately after a run completes
//   Y_in        : output of the gate under test
//   A_out,B_out : registered stimulus to the gate
//   busy        : high while settling or sampling
//   done        : one-cycle pulse at run completion
//   pass        : last completed run had no mismatch
//   fail_mask   : per-vector mismatch flags of the last completed run
//   pass_count  : passing runs since reset, saturating at 255
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       loop,
  input  logic       Y_in,
  output logic       A_out,
  output logic       B_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] pass_count
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [1:0] LAST_IDX  = 2'(NUM_VECTORS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_index;
  logic [3:0] r_mask;
  logic       w_start_run;
  logic       w_next_vec;
  logic       w_finish;
  logic       w_dec;
  logic       w_zero;
  logic       w_mismatch;
  logic [3:0] w_mask_upd;

  assign w_mismatch = (Y_in != TRUTH[r_index]);
  // Working mask including the vector sampled on this edge.
  assign w_mask_upd = r_mask | ({3'b000, w_mismatch} << r_index);

  settle_timer #(.W(4)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_run | w_next_vec),
    .i_load_val (SETTLE_M1),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    w_next_vec  = 1'b0;
    w_finish    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next      = ST_SETTLE;
          w_start_run = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_zero) begin
          w_next = ST_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (r_index == LAST_IDX) begin
          w_next   = ST_DONE;
          w_finish = 1'b1;
        end else begin
          w_next     = ST_SETTLE;
          w_next_vec = 1'b1;
        end
      end
      ST_DONE: begin
        if (loop) begin
          w_next      = ST_SETTLE;
          w_start_run = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= '0;
      r_mask     <= '0;
      A_out      <= 1'b0;
      B_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      pass_count <= '0;
    end else begin
      busy <= (w_next == ST_SETTLE) || (w_next == ST_SAMPLE);
      done <= (w_next == ST_DONE);
      if (w_start_run) begin
        r_index        <= '0;
        r_mask         <= '0;
        {A_out, B_out} <= 2'b00;
      end else if (w_next_vec) begin
        r_index        <= r_index + 2'd1;
        r_mask         <= w_mask_upd;
        {A_out, B_out} <= r_index + 2'd1;
      end else if (w_finish) begin
        fail_mask <= w_mask_upd;
        pass      <= (w_mask_upd == 4'b0000);
        if ((w_mask_upd == 4'b0000) && (pass_count != 8'hFF)) begin
          pass_count <= pass_count + 8'd1;
        end
      end else if (r_state == ST_DONE) begin
        {A_out, B_out} <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// tb/tb_gate_tester.sv - self-checking bench for gate_tester
module tb_gate_tester;

  localparam logic [3:0] TRUTH  = 4'b0111;
  localparam int         SETTLE = 2;
  localparam int         RUN_LEN = 4 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       loop = 1'b0;
  logic       Y_in;
  logic       A_out, B_out, busy, done, pass;
  logic [3:0] fail_mask;
  logic [7:0] pass_count;

  logic [3:0] gate_tbl = 4'b0111;   // behaviour of the simulated gate, indexed by {A,B}
  int n_cmp = 0;
  int n_bad = 0;
  int model_count = 0;
  logic [3:0] model_mask = '0;
  logic       model_pass = 1'b0;

  assign Y_in = gate_tbl[{A_out, B_out}];

  always #5 clk = ~clk;

  gate_tester #(.TRUTH(TRUTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .Y_in(Y_in),
    .A_out(A_out), .B_out(B_out), .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .pass_count(pass_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a run fails exactly on the vectors where the gate differs from TRUTH.
  task automatic model_run();
    model_mask = gate_tbl ^ TRUTH;
    model_pass = (model_mask == 4'b0000);
    if (model_pass && model_count < 255) model_count++;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_pass"}, pass, model_pass);
    check({tag, "_mask"}, fail_mask, model_mask);
    check({tag, "_cnt"}, pass_count, model_count);
  endtask

  // One run from a start pulse; optionally re-pulse start at cycles 3 and 8.
  task automatic one_run(input string tag, input bit repulse);
    int k;
    int seen;
    int extra;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (k = 1; k <= RUN_LEN + 8; k++) begin
      @(posedge clk); @(negedge clk);
      start = repulse && (k == 3 || k == 8);
      if (k == 1) check({tag, "_busy"}, busy, 1'b1);
      if (done) begin seen = k; break; end
    end
    start = 1'b0;
    check({tag, "_lat"}, seen, RUN_LEN);
    model_run();
    check_results(tag);
    extra = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, "_idle"}, extra, 0);
    check({tag, "_ab"}, {A_out, B_out}, 2'b00);
  endtask

  // Looping runs: done pulses must be RUN_LEN+1 apart after the first.
  task automatic loop_runs(input string tag, input int n);
    int last;
    int runs;
    int k;
    last = 0; runs = 0;
    loop = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (k = 1; k <= n * (RUN_LEN + 1) + 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        if (last == 0) check({tag, "_first"}, k, RUN_LEN);
        else if (k - last != RUN_LEN + 1) check({tag, "_gap"}, k - last, RUN_LEN + 1);
        last = k;
        model_run();
        runs++;
        if (runs == n) begin loop = 1'b0; break; end
      end
    end
    check({tag, "_runs"}, runs, n);
    check_results(tag);
    repeat (3) @(negedge clk);
    check({tag, "_stop"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    int dn;
    #12;
    check("reset_outs", {A_out, B_out, busy, done, pass, fail_mask, pass_count}, 17'd0);
    @(negedge clk); rst_n = 1'b1;

    gate_tbl = 4'b0111; one_run("nand", 1'b0);
    gate_tbl = 4'b1000; one_run("and", 1'b0);
    gate_tbl = 4'b1111; one_run("y1", 1'b0);
    gate_tbl = 4'b0000; one_run("y0", 1'b0);
    gate_tbl = 4'b0111; one_run("repulse", 1'b1);

    for (int r = 0; r < 16; r++) begin
      gate_tbl = (r % 4 == 0) ? TRUTH : 4'($urandom_range(0, 15));
      one_run("rand", 1'b0);
    end

    // Reset mid-run at cycle 6.
    gate_tbl = 4'b0111;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (k = 1; k < 6; k++) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {A_out, B_out, busy, done, pass, fail_mask, pass_count}, 17'd0);
    model_count = 0; model_mask = '0; model_pass = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int j = 0; j < 20; j++) begin @(posedge clk); @(negedge clk); if (done) dn++; end
    check("midrst_nodone", dn, 0);
    one_run("afterrst", 1'b0);

    gate_tbl = 4'b0111;
    loop_runs("loop3", 3);
    loop_runs("loopsat", 260);
    check("sat_cnt", pass_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b0111, meaning expected Y for input vector {A,B}=i at bit i (default = 2-input NAND).
REQ-002 SHALL have parameter SETTLE, default 2, meaning cycles each vector is held before Y is sampled (legal range 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst_n input 1.
REQ-004 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-005 SHALL have port loop, input, 1 bit: when high at end of a run, the next run starts immediately.
REQ-006 SHALL have port Y_in, input, 1 bit: output of the 2-input gate under test.
REQ-007 SHALL have ports A_out and B_out, outputs, 1 bit each: registered stimulus to the gate under test.
REQ-008 SHALL have port busy, output, 1 bit: high in SETTLE or SAMPLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at run completion.
REQ-010 SHALL have port pass, output, 1 bit: result of last completed run, held until the next run starts.
REQ-011 SHALL have port fail_mask, output, 4 bits: bit i set if vector i mismatched in the last completed run.
REQ-012 SHALL have port pass_count, output, 8 bits: number of passing runs since reset, saturating at 255.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-014 SHALL, in IDLE with start=1 at a clock edge, load index 0, drive {A_out,B_out}=00, load settle counter with SETTLE-1, clear working mismatch mask, enter SETTLE.
REQ-015 SHALL, in SETTLE, decrement the counter each edge and enter SAMPLE on the edge where counter=0.
REQ-016 SHALL, in SAMPLE, compare Y_in with TRUTH[index] on the edge and set working mask bit index on mismatch.
REQ-017 SHALL, from SAMPLE with index<3, increment index, drive {A_out,B_out}=next index, reload counter, enter SETTLE; with index=3, enter DONE.
REQ-018 SHALL apply vectors in order 00, 01, 10, 11; each vector held exactly SETTLE+1 cycles.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, update fail_mask from working mask, pass = (mask==0), increment pass_count if pass and pass_count<255.
REQ-020 SHALL, on the edge leaving DONE, go to SETTLE with index 0 (as REQ-014) if loop=1, else IDLE with {A_out,B_out}=00.
REQ-021 SHALL assert done in the cycle beginning 4*(SETTLE+1) edges after the accepting start edge.
REQ-022 SHALL ignore start while busy or in DONE; no queuing.
REQ-023 SHALL hold pass and fail_mask at previous-run values during a run; clear neither until DONE of the next run.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, A_out=0, B_out=0, busy=0, done=0, pass=0, fail_mask=0000, pass_count=0, index=0, counter=0.
REQ-025 SHALL, on reset mid-run, abort without a done pulse; the partial result is discarded.

Structure
REQ-026 SHALL place the state encoding typedef and constant NUM_VECTORS=4 in a shared package gate_tester_pkg.
REQ-027 SHALL implement the settle countdown as sub-module settle_timer (load, decrement, zero flag).

Verification (SETTLE=2, TRUTH=4'b0111 unless stated)
REQ-028 SHALL cover: NAND gate on A_out/B_out, start pulse -> done exactly 12 cycles after start edge, pass=1, fail_mask=0000, pass_count=1.
REQ-029 SHALL cover: AND gate under test -> pass=0, fail_mask=1111, pass_count unchanged.
REQ-030 SHALL cover: Y_in tied to 1 -> fail_mask=1000, pass=0; Y_in tied to 0 -> fail_mask=0111.
REQ-031 SHALL cover: start re-pulsed at cycles 3 and 8 of a run -> single done pulse at cycle 12, no second run.
REQ-032 SHALL cover: rst_n low at cycle 6 of a run -> all outputs at reset values immediately, no done; new start after release -> normal run.
REQ-033 SHALL cover: loop=1 with NAND for 3 runs -> done pulses 13 cycles apart, pass_count=3; preloaded to 255 -> stays 255.
